// File: rtl/light_monitor_pkg.sv
// Shared types and encodings for the street-light sequence monitor.
package light_monitor_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_GREEN,
    ST_YELLOW,
    ST_RED,
    ST_FAULT
  } state_e;

  localparam logic [1:0] PH_NONE   = 2'd0;
  localparam logic [1:0] PH_GREEN  = 2'd1;
  localparam logic [1:0] PH_YELLOW = 2'd2;
  localparam logic [1:0] PH_RED    = 2'd3;

  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_BAD_ENCODING = 3'd1;
  localparam logic [2:0] FC_BAD_ORDER    = 3'd2;
  localparam logic [2:0] FC_SHORT_DWELL  = 3'd3;
  localparam logic [2:0] FC_STUCK        = 3'd4;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  function automatic logic is_one_hot(input logic [2:0] code);
    return $onehot(code);
  endfunction

endpackage

// File: rtl/light_monitor_dwell_counter.sv
// Saturating per-phase dwell counter; load1 restarts a phase at one sample.
module dwell_counter #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_DWELL = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load1,
  input  logic             inc,
  output logic [CNT_W-1:0] dwell,
  output logic             at_max
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell <= '0;
    end else if (load1) begin
      dwell <= CNT_W'(1);
    end else if (inc && (dwell != '1)) begin
      dwell <= dwell + 1'b1;
    end
  end

  assign at_max = (dwell == CNT_W'(MAX_DWELL));

endmodule

// File: rtl/light_monitor.sv
// Passive checker for the street_lights lamp sequence: order, dwell limits,
// sticky first-fault capture and completed-cycle counting.
module light_monitor
  import light_monitor_pkg::*;
#(
  parameter int unsigned MIN_GREEN  = 4,
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned MIN_RED    = 4,
  parameter int unsigned MAX_DWELL  = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        light_one,
  input  logic        light_two,
  input  logic        light_three,
  input  logic        clear,
  output logic [1:0]  phase,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [15:0] cycle_count,
  output logic        cycle_done
);

  state_e           state;
  logic [2:0]       code_q;
  logic             exempt_q;
  logic [15:0]      cycle_cnt_q;

  logic [CNT_W-1:0] dwell;
  logic             at_max;
  logic             load1;
  logic             inc;

  state_e           code_state;
  logic [1:0]       code_phase;
  logic [2:0]       cur_lamp;
  logic [2:0]       succ_lamp;
  logic [CNT_W-1:0] min_dwell;
  logic             in_phase;
  logic             onehot;
  logic             hold;
  logic             to_succ;
  logic             short_dwell;
  logic             enter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= '0;
    end else begin
      code_q <= {light_three, light_two, light_one};
    end
  end

  always_comb begin
    code_state = ST_INIT;
    code_phase = PH_NONE;
    case (code_q)
      LAMP_GREEN:  begin code_state = ST_GREEN;  code_phase = PH_GREEN;  end
      LAMP_YELLOW: begin code_state = ST_YELLOW; code_phase = PH_YELLOW; end
      LAMP_RED:    begin code_state = ST_RED;    code_phase = PH_RED;    end
      default: ;
    endcase

    cur_lamp  = '0;
    succ_lamp = '0;
    min_dwell = '0;
    in_phase  = 1'b1;
    case (state)
      ST_GREEN: begin
        cur_lamp  = LAMP_GREEN;
        succ_lamp = LAMP_YELLOW;
        min_dwell = CNT_W'(MIN_GREEN);
      end
      ST_YELLOW: begin
        cur_lamp  = LAMP_YELLOW;
        succ_lamp = LAMP_RED;
        min_dwell = CNT_W'(MIN_YELLOW);
      end
      ST_RED: begin
        cur_lamp  = LAMP_RED;
        succ_lamp = LAMP_GREEN;
        min_dwell = CNT_W'(MIN_RED);
      end
      default: in_phase = 1'b0;
    endcase

    onehot      = is_one_hot(code_q);
    hold        = in_phase && (code_q == cur_lamp);
    to_succ     = in_phase && (code_q == succ_lamp);
    short_dwell = !exempt_q && (dwell < min_dwell);
    enter       = (state == ST_INIT) && onehot;
    load1       = !clear && (enter || (to_succ && !short_dwell));
    inc         = !clear && hold && !at_max;
  end

  dwell_counter #(
    .CNT_W     (CNT_W),
    .MAX_DWELL (MAX_DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .load1  (load1),
    .inc    (inc),
    .dwell  (dwell),
    .at_max (at_max)
  );

  // Hold and successor are mutually exclusive one-hot matches, so testing
  // hold before the successor keeps the documented check priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_INIT;
      phase       <= PH_NONE;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      cycle_cnt_q <= '0;
      cycle_done  <= 1'b0;
      exempt_q    <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (clear) begin
        state       <= ST_INIT;
        phase       <= PH_NONE;
        fault       <= 1'b0;
        fault_code  <= FC_NONE;
        cycle_cnt_q <= '0;
        exempt_q    <= 1'b0;
      end else begin
        case (state)
          ST_INIT: begin
            if (enter) begin
              state    <= code_state;
              phase    <= code_phase;
              exempt_q <= 1'b1;
            end else if (code_q != '0) begin
              state      <= ST_FAULT;
              fault      <= 1'b1;
              fault_code <= FC_BAD_ENCODING;
            end
          end
          ST_GREEN, ST_YELLOW, ST_RED: begin
            if (!onehot) begin
              state      <= ST_FAULT;
              fault      <= 1'b1;
              fault_code <= FC_BAD_ENCODING;
            end else if (hold) begin
              if (at_max) begin
                state      <= ST_FAULT;
                fault      <= 1'b1;
                fault_code <= FC_STUCK;
              end
            end else if (!to_succ) begin
              state      <= ST_FAULT;
              fault      <= 1'b1;
              fault_code <= FC_BAD_ORDER;
            end else if (short_dwell) begin
              state      <= ST_FAULT;
              fault      <= 1'b1;
              fault_code <= FC_SHORT_DWELL;
            end else begin
              state    <= code_state;
              phase    <= code_phase;
              exempt_q <= 1'b0;
              if (state == ST_RED) begin
                cycle_cnt_q <= cycle_cnt_q + 16'd1;
                cycle_done  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_light_monitor.sv
// Scoreboard bench for light_monitor: directed scenarios plus random lamp
// sequences, checked against a phase-level reference model.
module tb_light_monitor;

  localparam int MIN_GREEN  = 4;
  localparam int MIN_YELLOW = 2;
  localparam int MIN_RED    = 4;
  localparam int MAX_DWELL  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        light_one = 1'b0, light_two = 1'b0, light_three = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  phase;
  logic        fault;
  logic [2:0]  fault_code;
  logic [15:0] cycle_count;
  logic        cycle_done;

  light_monitor #(
    .MIN_GREEN  (MIN_GREEN),
    .MIN_YELLOW (MIN_YELLOW),
    .MIN_RED    (MIN_RED),
    .MAX_DWELL  (MAX_DWELL),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .light_one   (light_one),
    .light_two   (light_two),
    .light_three (light_three),
    .clear       (clear),
    .phase       (phase),
    .fault       (fault),
    .fault_code  (fault_code),
    .cycle_count (cycle_count),
    .cycle_done  (cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ph;
    logic        flt;
    logic [2:0]  fc;
    logic [15:0] cnt;
    logic        done;
  } obs_t;

  obs_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: phases numbered 1..3 in legal order, 0 = not started.
  logic [2:0]  m_lamps;
  int          m_phase, m_dwell, m_fc;
  bit          m_run, m_exempt, m_fault, m_done;
  logic [15:0] m_cnt;
  int          min_of[4] = '{0, MIN_GREEN, MIN_YELLOW, MIN_RED};

  function automatic int lamp_phase(input logic [2:0] c);
    if (c == 3'b001) return 1;
    if (c == 3'b010) return 2;
    if (c == 3'b100) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_lamps = 3'b000; m_phase = 0; m_dwell = 0; m_fc = 0;
    m_run = 0; m_exempt = 0; m_fault = 0; m_done = 0; m_cnt = 16'd0;
  endtask

  task automatic raise(input int code);
    m_fault = 1; m_fc = code;
  endtask

  task automatic model_step(input logic [2:0] lamps, input bit clr);
    int p;
    m_done = 0;
    if (clr) begin
      m_phase = 0; m_fault = 0; m_fc = 0; m_cnt = 16'd0; m_run = 0;
    end else if (!m_fault) begin
      if ($countones(m_lamps) != 1) begin
        if (m_run || m_lamps != 3'b000) raise(1);
      end else begin
        p = lamp_phase(m_lamps);
        if (!m_run) begin
          m_run = 1; m_phase = p; m_dwell = 1; m_exempt = 1;
        end else if (p == m_phase) begin
          if (m_dwell == MAX_DWELL) raise(4);
          else m_dwell++;
        end else if (p != (m_phase % 3) + 1) begin
          raise(2);
        end else if (m_dwell < min_of[m_phase] && !m_exempt) begin
          raise(3);
        end else begin
          if (m_phase == 3) begin
            m_cnt = m_cnt + 16'd1;
            m_done = 1;
          end
          m_phase = p; m_dwell = 1; m_exempt = 0;
        end
      end
    end
    m_lamps = lamps;
  endtask

  task automatic apply(input logic [2:0] lamps, input bit clr);
    {light_three, light_two, light_one} = lamps;
    clear = clr;
    model_step(lamps, clr);
    exp_q.push_back('{ph: 2'(m_phase), flt: m_fault, fc: 3'(m_fc),
                      cnt: m_cnt, done: m_done});
  endtask

  task automatic drive(input logic [2:0] lamps, input bit clr);
    @(negedge clk);
    apply(lamps, clr);
  endtask

  task automatic hold_lamp(input logic [2:0] lamps, input int n);
    for (int i = 0; i < n; i++) drive(lamps, 1'b0);
  endtask

  task automatic do_clear();
    drive(3'b000, 1'b1);
    drive(3'b000, 1'b0);
  endtask

  task automatic check_zero(input string name);
    obs_t a;
    a = '{ph: phase, flt: fault, fc: fault_code, cnt: cycle_count, done: cycle_done};
    n_checks++;
    if (a !== '0) begin
      n_fail++;
      $display("FAIL %s: got phase=%0d fault=%0d code=%0d count=%0d done=%0d, want all zero",
               name, a.ph, a.flt, a.fc, a.cnt, a.done);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    {light_three, light_two, light_one} = 3'b000;
    clear = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("reset_async");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(3'b000, 1'b0);
  endtask

  task automatic check_now(input string name, input int ph, input int flt,
                           input int fc, input int cnt, input int done);
    obs_t a, e;
    @(posedge clk);
    #2;
    a = '{ph: phase, flt: fault, fc: fault_code, cnt: cycle_count, done: cycle_done};
    e = '{ph: 2'(ph), flt: 1'(flt), fc: 3'(fc), cnt: 16'(cnt), done: 1'(done)};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got phase=%0d fault=%0d code=%0d count=%0d done=%0d, want phase=%0d fault=%0d code=%0d count=%0d done=%0d",
               name, a.ph, a.flt, a.fc, a.cnt, a.done, e.ph, e.flt, e.fc, e.cnt, e.done);
    end
  endtask

  task automatic one_cycle();
    hold_lamp(3'b001, MIN_GREEN);
    hold_lamp(3'b010, MIN_YELLOW);
    hold_lamp(3'b100, MIN_RED);
  endtask

  // Monitor: every sampled output set is popped and compared against the model.
  initial begin
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{ph: phase, flt: fault, fc: fault_code, cnt: cycle_count, done: cycle_done};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: got phase=%0d fault=%0d code=%0d count=%0d done=%0d, want phase=%0d fault=%0d code=%0d count=%0d done=%0d",
                   $time, a.ph, a.flt, a.fc, a.cnt, a.done, e.ph, e.flt, e.fc, e.cnt, e.done);
        end
      end
    end
  end

  initial begin
    logic [2:0] seq_lamps[3];
    int         idx, n, r;
    seq_lamps = '{3'b001, 3'b010, 3'b100};
    model_reset();
    #2;
    check_zero("reset_state");
    do_reset();

    repeat (3) one_cycle();
    drive(3'b100, 1'b0);
    check_now("three_cycles", 3, 0, 0, 2, 0);
    do_clear();
    check_now("clear_after_cycles", 0, 0, 0, 0, 0);

    hold_lamp(3'b001, 4);
    drive(3'b011, 1'b0);
    drive(3'b000, 1'b0);
    check_now("bad_encoding", 1, 1, 1, 0, 0);
    drive(3'b000, 1'b0);
    check_now("fault_sticky", 1, 1, 1, 0, 0);
    do_clear();
    check_now("clear_fault", 0, 0, 0, 0, 0);

    hold_lamp(3'b001, 4);
    drive(3'b100, 1'b0);
    drive(3'b000, 1'b0);
    check_now("bad_order", 1, 1, 2, 0, 0);
    do_clear();

    hold_lamp(3'b001, 4);
    hold_lamp(3'b010, 1);
    drive(3'b100, 1'b0);
    drive(3'b000, 1'b0);
    check_now("short_yellow", 2, 1, 3, 0, 0);
    do_clear();

    hold_lamp(3'b001, MAX_DWELL + 1);
    drive(3'b000, 1'b0);
    check_now("stuck_green", 1, 1, 4, 0, 0);
    do_clear();

    hold_lamp(3'b001, MAX_DWELL);
    hold_lamp(3'b010, 3);
    check_now("green_max_ok", 2, 0, 0, 0, 0);

    do_reset();
    drive(3'b010, 1'b0);
    hold_lamp(3'b100, 3);
    check_now("first_phase_exempt", 3, 0, 0, 0, 0);
    do_reset();

    one_cycle();
    @(negedge clk);
    force dut.cycle_cnt_q = 16'hFFFF;
    #1;
    release dut.cycle_cnt_q;
    m_cnt = 16'hFFFF;
    apply(3'b100, 1'b0);
    drive(3'b001, 1'b0);
    drive(3'b001, 1'b0);
    check_now("count_wrap", 1, 0, 0, 0, 1);
    check_now("done_one_shot", 1, 0, 0, 0, 0);
    do_clear();

    hold_lamp(3'b001, 4);
    drive(3'b011, 1'b0);
    drive(3'b000, 1'b1);
    drive(3'b000, 1'b0);
    check_now("clear_beats_fault", 0, 0, 0, 0, 0);

    idx = 0;
    repeat (300) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        drive(3'($urandom_range(0, 7)), 1'b0);
      end else if (r < 15) begin
        do_clear();
        idx = 0;
      end else begin
        n = (r < 22) ? $urandom_range(MAX_DWELL - 2, MAX_DWELL + 2)
                     : $urandom_range(1, 7);
        hold_lamp(seq_lamps[idx], n);
        idx = (idx + 1) % 3;
      end
    end

    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/light_monitor.md
# light_monitor

Passive checker that sits on the three light outputs of `street_lights` and reads back the sequence the controller drives. It decodes the lamp pattern into a phase and enforces legal order (green -> yellow -> red -> green) and per-phase minimum and maximum dwell times. It latches the first violation as a sticky fault and counts completed light cycles. It is instantiated beside `street_lights` in the top level and in benches, and never drives the lights.

## Interface
- `MIN_GREEN`, 4: minimum legal green dwell, clock cycles.
- `MIN_YELLOW`, 2: minimum legal yellow dwell, clock cycles.
- `MIN_RED`, 4: minimum legal red dwell, clock cycles.
- `MAX_DWELL`, 64: maximum dwell of any phase before a stuck fault; must exceed every MIN.
- `CNT_W`, 8: dwell counter width; 2^CNT_W-1 >= MAX_DWELL.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `light_one` in 1: green lamp.
- `light_two` in 1: yellow lamp.
- `light_three` in 1: red lamp.
- `clear` in 1: synchronous; clears the fault and the cycle count and returns to INIT.
- `phase` out 2: 0 none/INIT, 1 green, 2 yellow, 3 red.
- `fault` out 1: sticky violation flag.
- `fault_code` out 3: 0 none, 1 BAD_ENCODING, 2 BAD_ORDER, 3 SHORT_DWELL, 4 STUCK.
- `cycle_count` out 16: completed red->green transitions; wraps.
- `cycle_done` out 1: one-cycle pulse per completed cycle.

## Operation
- Lamps are registered into `code = {light_three, light_two, light_one}` every cycle. All checks act on this registered code.
- FSM states: INIT, GREEN, YELLOW, RED, FAULT.
- INIT:
  - code 000 is tolerated indefinitely.
  - Any single one-hot code enters that phase with dwell=1. The first phase entered from INIT is exempt from its MIN check.
  - Any multi-hot code goes to FAULT with code 1.
- In a phase, each cycle is evaluated in this priority:
  - code not one-hot, including 000: FAULT, code 1.
  - code is a one-hot other than the current phase and not its successor: FAULT, code 2.
  - code is the successor and dwell < MIN of the current phase (and the exemption does not apply): FAULT, code 3.
  - code is the successor, legal: enter the successor with dwell=1. RED->GREEN also increments `cycle_count` and pulses `cycle_done`.
  - code unchanged and dwell == MAX_DWELL: FAULT, code 4.
  - code unchanged otherwise: dwell+1.
- FAULT:
  - `fault`=1. `fault_code` holds the first violation; later violations are ignored.
  - `phase` holds the value it had when the fault hit.
  - Only `clear` or `rst` leave FAULT.
- `clear` (any state): next edge gives INIT, `fault`=0, `fault_code`=0, `cycle_count`=0, `phase`=0. `clear` has priority over every check in the same cycle.
- `cycle_count` wraps 0xFFFF -> 0x0000 with `cycle_done` still pulsed.

## Timing
- Reset values: `phase`=0, `fault`=0, `fault_code`=0, `cycle_count`=0, `cycle_done`=0, FSM in INIT, code register 000, dwell 0.
- Latency: a lamp change set up before edge N is captured at edge N; `phase`, `fault`, `fault_code`, `cycle_count` and `cycle_done` reflect it after edge N+1.
- Dwell semantics: a phase held for k sampled cycles has dwell=k at its last sampled cycle. A hold of exactly MIN cycles is legal. STUCK fires on the (MAX_DWELL+1)th sampled cycle of the same phase.
- `cycle_done` is high for exactly one cycle, coincident with the `cycle_count` update.
- `rst` mid-operation clears everything immediately and asynchronously. The first post-reset sample behaves as in INIT.

## Structure
- `light_monitor_pkg` holds:
  - the state enum;
  - phase encodings 0-3;
  - fault codes 0-4;
  - the one-hot lamp constants GREEN=3'b001, YELLOW=3'b010, RED=3'b100.
- Sub-module `dwell_counter`: CNT_W-bit saturating counter with `load1` and `inc` inputs and an `at_max` output (compared against MAX_DWELL). The FSM, checks and cycle counter stay in `light_monitor`.

## Test plan
- Reset, then green 4 / yellow 2 / red 4 cycles, repeated 3 times -> `fault`=0, `cycle_count`=2, with one `cycle_done` pulse at each red->green.
- From green, drive 011 for one cycle -> `fault`=1, `fault_code`=1, `phase`=1 held. Then pulse `clear` -> `fault`=0, `phase`=0, `cycle_count`=0.
- Green 4, then red -> `fault_code`=2. Separately, green 4, yellow 1, red -> `fault_code`=3.
- Hold green 65 cycles with MAX_DWELL=64 -> `fault_code`=4 after edge 66 of the hold. Holding 64 cycles then going yellow -> no fault.
- Start from reset directly in yellow for 1 cycle, then red -> no fault (exemption). Assert `rst` mid-red -> all outputs 0 immediately.
- Preload 0xFFFF completed cycles (or force), then one more red->green -> `cycle_count`=0x0000 with `cycle_done`=1. `clear` asserted in the same cycle as a violation -> no fault.
